// File: rtl/alu_multicycle.sv
// alu_multicycle: registered LEGv8-style ALU with a start/done handshake.
// Operands and function select are taken when start is seen in IDLE.
// One-cycle ops (AND/OR/ADD/XOR/LSL/LSR/ASR) report done on the next cycle.
// Optional macro ALU_MULTICYCLE_MUL_EN enables an iterative shift-add
// multiplier (FS[4:2] = 110) that runs for N cycles in a RUN state. Without
// the macro, that opcode completes in one cycle with F = 0, status = 4'b0001.
//
// Ports:
//   clock   - rising-edge clock
//   reset   - synchronous, active-high
//   start   - request, accepted only in IDLE
//   A, B    - N-bit operands
//   FS      - function select: FS[0] inverts A, FS[1] inverts B, FS[4:2] op
//   C0      - adder carry-in
//   busy    - high whenever not in IDLE
//   done    - one-cycle pulse; F and status valid from this cycle
//   F       - N-bit result register
//   status  - {V, C, N, Z}
module alu_multicycle #(
  parameter int N  = 64,
  parameter int SW = $clog2(N)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [4:0]   FS,
  input  logic         C0,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] F,
  output logic [3:0]   status
);

`ifdef ALU_MULTICYCLE_MUL_EN
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_DONE} state_t;
`endif

  state_t r_state;
  state_t w_next_state;

  // One-cycle result path, evaluated directly from the inputs on acceptance.
  logic [N-1:0]  w_as;
  logic [N-1:0]  w_bs;
  logic [N:0]    w_sum;
  logic [SW-1:0] w_sh;
  logic [N-1:0]  w_res;
  logic          w_c;
  logic          w_v;
  logic [3:0]    w_stat;
  logic          w_is_mul;

`ifdef ALU_MULTICYCLE_MUL_EN
  localparam int CW = (N > 2) ? $clog2(N) : 1;
  logic [N-1:0]   r_a;
  logic [2*N-1:0] r_acc;
  logic [CW-1:0]  r_cnt;
  logic [N:0]     w_upper;
  logic [2*N-1:0] w_acc_next;

  // Right-shifting shift-add: low half of the accumulator starts as B and is
  // consumed one bit per step while the partial product fills the top.
  always_comb begin
    w_upper = {1'b0, r_acc[2*N-1:N]};
    if (r_acc[0]) begin
      w_upper = {1'b0, r_acc[2*N-1:N]} + {1'b0, r_a};
    end
    w_acc_next = {w_upper, r_acc[N-1:1]};
  end

  assign w_is_mul = (FS[4:2] == 3'b110);
`else
  assign w_is_mul = 1'b0;
`endif

  always_comb begin
    w_as  = FS[0] ? ~A : A;
    w_bs  = FS[1] ? ~B : B;
    w_sum = {1'b0, w_as} + {1'b0, w_bs} + {{N{1'b0}}, C0};
    w_sh  = B[SW-1:0];
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (FS[4:2])
      3'b000: w_res = w_as & w_bs;
      3'b001: w_res = w_as | w_bs;
      3'b010: begin
        w_res = w_sum[N-1:0];
        w_c   = w_sum[N];
        w_v   = ~(w_as[N-1] ^ w_bs[N-1]) & (w_sum[N-1] ^ w_as[N-1]);
      end
      3'b011: w_res = w_as ^ w_bs;
      3'b100: w_res = A << w_sh;
      3'b101: w_res = A >> w_sh;
      3'b110: w_res = '0;
      default: w_res = $unsigned($signed(A) >>> w_sh);
    endcase
    w_stat = {w_v, w_c, w_res[N-1], (w_res == '0)};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    busy         = (r_state != S_IDLE);
    done         = (r_state == S_DONE);
    case (r_state)
      S_IDLE: begin
        if (start) begin
`ifdef ALU_MULTICYCLE_MUL_EN
          w_next_state = w_is_mul ? S_RUN : S_DONE;
`else
          w_next_state = S_DONE;
`endif
        end
      end
`ifdef ALU_MULTICYCLE_MUL_EN
      S_RUN: begin
        if (r_cnt == '0) begin
          w_next_state = S_DONE;
        end
      end
`endif
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      F      <= '0;
      status <= '0;
`ifdef ALU_MULTICYCLE_MUL_EN
      r_a    <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_is_mul) begin
`ifdef ALU_MULTICYCLE_MUL_EN
              r_a   <= A;
              r_acc <= {{N{1'b0}}, B};
              r_cnt <= CW'(N - 1);
`endif
            end else begin
              F      <= w_res;
              status <= w_stat;
            end
          end
        end
`ifdef ALU_MULTICYCLE_MUL_EN
        S_RUN: begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == '0) begin
            F      <= w_acc_next[N-1:0];
            status <= {(w_acc_next[2*N-1:N] != '0), 1'b0,
                       w_acc_next[N-1], (w_acc_next[N-1:0] == '0)};
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
module tb_alu_multicycle;

  localparam int W = 64;

  logic         clock;
  logic         reset;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [4:0]   FS;
  logic         C0;
  logic         busy;
  logic         done;
  logic [W-1:0] F;
  logic [3:0]   status;

  int checks = 0;
  int errors = 0;

  alu_multicycle #(.N(W)) dut (
    .clock(clock), .reset(reset), .start(start), .A(A), .B(B), .FS(FS),
    .C0(C0), .busy(busy), .done(done), .F(F), .status(status)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

`ifdef ALU_MULTICYCLE_MUL_EN
  localparam int MUL_LAT = W + 1;
`else
  localparam int MUL_LAT = 1;
`endif

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: plain arithmetic on whole words.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [4:0] fs, input logic c0,
                                output logic [W-1:0] f, output logic [3:0] st,
                                output int lat);
    logic [W-1:0]   as, bs, ones;
    logic [W:0]     wide;
    logic [2*W-1:0] p;
    int             s;
    logic           v, c;
    as = fs[0] ? ~a : a;
    bs = fs[1] ? ~b : b;
    ones = '1;
    s = int'(b[5:0]);
    v = 1'b0; c = 1'b0; lat = 1; f = '0;
    case (fs[4:2])
      3'd0: f = as & bs;
      3'd1: f = as | bs;
      3'd2: begin
        wide = {1'b0, as} + {1'b0, bs} + (W+1)'(c0);
        f = wide[W-1:0];
        c = wide[W];
        v = (as[W-1] == bs[W-1]) && (f[W-1] != as[W-1]);
      end
      3'd3: f = as ^ bs;
      3'd4: f = a << s;
      3'd5: f = a >> s;
      3'd6: begin
`ifdef ALU_MULTICYCLE_MUL_EN
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        f = p[W-1:0];
        v = (p[2*W-1:W] != '0);
        lat = W + 1;
`else
        p = '0;
        f = p[W-1:0];
`endif
      end
      default: f = (a >> s) | (a[W-1] ? ~(ones >> s) : '0);
    endcase
    st = {v, c, f[W-1], (f == '0)};
  endfunction

  // Issue one request and watch a fixed window after it. inject_at > 0
  // raises start with an ADD (1 + 1) in that cycle after acceptance.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [4:0] fs, input logic c0,
                        input logic [W-1:0] exp_f, input logic [3:0] exp_st,
                        input int exp_lat, input int inject_at);
    int cyc, busy_cnt, done_cnt, lat;
    logic [W-1:0] f_obs;
    logic [3:0]   s_obs;
    @(negedge clock);
    A = a; B = b; FS = fs; C0 = c0; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    busy_cnt = 0; done_cnt = 0; lat = -1; f_obs = '0; s_obs = '0;
    for (cyc = 1; cyc <= exp_lat + 3; cyc++) begin
      if (cyc == inject_at) begin
        A = 1; B = 1; FS = 5'b01000; C0 = 1'b0; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_cnt == 1) begin
          lat = cyc; f_obs = F; s_obs = status;
        end
      end
      @(negedge clock);
    end
    start = 1'b0;
    check({tag, " done_pulses"}, W'(done_cnt), W'(1));
    check({tag, " latency"}, W'(lat), W'(exp_lat));
    check({tag, " busy_cycles"}, W'(busy_cnt), W'(exp_lat));
    check({tag, " F"}, f_obs, exp_f);
    check({tag, " status"}, W'(s_obs), W'(exp_st));
    check({tag, " F_hold"}, F, exp_f);
    check({tag, " idle_busy"}, W'(busy), W'(0));
  endtask

  initial begin
    logic [W-1:0] ra, rb, ef;
    logic [4:0]   rfs;
    logic         rc0;
    logic [3:0]   est;
    int           elat, dcnt;

    reset = 1'b1; start = 1'b0; A = '0; B = '0; FS = '0; C0 = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("rst busy", W'(busy), W'(0));
    check("rst done", W'(done), W'(0));
    check("rst F", F, W'(0));
    check("rst status", W'(status), W'(0));
    reset = 1'b0;

    run_op("add", 64'd5, 64'd3, 5'b01000, 1'b0, 64'd8, 4'b0000, 1, 0);
    run_op("sub_eq", 64'd5, 64'd5, 5'b01010, 1'b1, 64'd0, 4'b0101, 1, 0);
`ifdef ALU_MULTICYCLE_MUL_EN
    run_op("mul_ovf", 64'h1_0000_0000, 64'h1_0000_0000, 5'b11000, 1'b0,
           64'd0, 4'b1001, MUL_LAT, 0);
    run_op("mul_inject", 64'd7, 64'd9, 5'b11000, 1'b0, 64'd63, 4'b0000, MUL_LAT, 10);
`else
    run_op("mul_off", 64'h1_0000_0000, 64'h1_0000_0000, 5'b11000, 1'b0,
           64'd0, 4'b0001, MUL_LAT, 0);
`endif
    run_op("asr", 64'h8000_0000_0000_0001, 64'd1, 5'b11100, 1'b0,
           64'hC000_0000_0000_0000, 4'b0010, 1, 0);
    run_op("lsr", 64'h8000_0000_0000_0001, 64'd1, 5'b10100, 1'b0,
           64'h4000_0000_0000_0000, 4'b0000, 1, 0);
    run_op("lsl", 64'h8000_0000_0000_0003, 64'd65, 5'b10000, 1'b0,
           64'h0000_0000_0000_0006, 4'b0000, 1, 0);
    run_op("ovf_add", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 5'b01000, 1'b0,
           64'h8000_0000_0000_0000, 4'b1010, 1, 0);
    // start held into the DONE cycle must not launch a second op
    run_op("start_in_done", 64'hF0, 64'h3C, 5'b00000, 1'b0, 64'h30, 4'b0000, 1, 1);

    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 3))
        0: begin ra = '1; rb = {$urandom, $urandom}; end
        1: begin ra = {1'b1, 63'd0}; rb = W'($urandom_range(0, 63)); end
        default: begin ra = {$urandom, $urandom}; rb = {$urandom, $urandom}; end
      endcase
      rfs = 5'($urandom_range(0, 31));
      rc0 = 1'($urandom_range(0, 1));
      model(ra, rb, rfs, rc0, ef, est, elat);
      run_op($sformatf("rand%0d fs=%b", i, rfs), ra, rb, rfs, rc0, ef, est, elat, 0);
    end

    // reset and start together: reset wins and the request is dropped
    run_op("pre_rst", 64'd5, 64'd3, 5'b01000, 1'b0, 64'd8, 4'b0000, 1, 0);
    @(negedge clock);
    reset = 1'b1; start = 1'b1; A = 64'd9; B = 64'd9; FS = 5'b01000;
    @(negedge clock);
    reset = 1'b0; start = 1'b0;
    check("rst_start busy", W'(busy), W'(0));
    check("rst_start F", F, W'(0));
    @(negedge clock);
    check("rst_start dropped_busy", W'(busy), W'(0));
    check("rst_start dropped_done", W'(done), W'(0));

`ifdef ALU_MULTICYCLE_MUL_EN
    run_op("pre_mulrst", 64'd5, 64'd3, 5'b01000, 1'b0, 64'd8, 4'b0000, 1, 0);
    @(negedge clock);
    A = 64'd3; B = 64'd5; FS = 5'b11000; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int k = 1; k < 20; k++) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("mulrst busy", W'(busy), W'(0));
    check("mulrst done", W'(done), W'(0));
    check("mulrst F", F, W'(0));
    check("mulrst status", W'(status), W'(0));
    dcnt = 0;
    for (int k = 0; k < 70; k++) begin
      @(negedge clock);
      if (done || busy) dcnt++;
    end
    check("mulrst no_done", W'(dcnt), W'(0));
    run_op("post_mulrst", 64'd6, 64'd7, 5'b11000, 1'b0, 64'd42, 4'b0000, MUL_LAT, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_multicycle.md
# alu_multicycle

Parametrised, registered successor to the LEGv8 combinational ALU. It adds a start/done handshake, an arithmetic shift right, and an optional iterative shift-add multiplier. Operands and function select are latched on `start`. One-cycle ops complete after a single cycle; the multiply runs for N cycles. It sits in the execute stage and stalls the datapath while `busy` is high.

## Interface
Parameters:
- `N`, default 64: operand and result width; must be ≥ 2.
- `SW`, default $clog2(N): shift-amount width, taken from B[SW-1:0].

Ports (clock and reset first):
- `clock`, input, 1: single clock; all state changes on the rising edge.
- `reset`, input, 1: synchronous, active-high.
- `start`, input, 1: request; accepted only in IDLE.
- `A`, input, N: operand A.
- `B`, input, N: operand B.
- `FS`, input, 5: function select. FS[0] inverts A, FS[1] inverts B, FS[4:2] selects the op.
- `C0`, input, 1: adder carry-in.
- `busy`, output, 1: high whenever the block is not in IDLE.
- `done`, output, 1: one-cycle pulse; F and status are valid from this cycle.
- `F`, output, N: result register.
- `status`, output, 4: {V, C, N, Z}.

## Operation
- Latch on acceptance: A, B, FS and C0 are captured when `start` is high in IDLE; inputs are ignored afterwards.
- Operand conditioning: A_s = FS[0] ? ~A : A; B_s = FS[1] ? ~B : B.
- FS[4:2] = 000: AND of A_s and B_s.
- FS[4:2] = 001: OR of A_s and B_s.
- FS[4:2] = 010: ADD, A_s + B_s + C0.
- FS[4:2] = 011: XOR of A_s and B_s.
- FS[4:2] = 100: LSL of raw A by B[SW-1:0].
- FS[4:2] = 101: LSR of raw A by B[SW-1:0].
- FS[4:2] = 110: MUL of raw A × raw B, unsigned; F = low N bits of the product.
- FS[4:2] = 111: ASR of raw A by B[SW-1:0], sign-filled from A[N-1].
- Status N: F[N-1]. Z: F == 0.
- Status for ADD: C = carry out of bit N-1; V = ~(A_s[N-1] ^ B_s[N-1]) & (F[N-1] ^ A_s[N-1]).
- Status for MUL: C = 0; V = 1 when the high N bits of the 2N-bit product are nonzero.
- Status for all other ops: C = 0, V = 0.
- States:
  - IDLE: `start` with a one-cycle op goes to DONE; `start` with MUL goes to RUN.
  - RUN: one shift-add step per cycle, with an internal 2N-bit accumulator and a counter from N-1 down to 0. Counter at 0 goes to DONE.
  - DONE: `done` = 1, then back to IDLE.
- F and status are written only on entry to DONE and hold until the next DONE.
- `start` in RUN or DONE is ignored; no queueing.
- Reset mid-operation: state goes to IDLE, the accumulator and counter clear, `done` is not pulsed, and the partial result is discarded.

## Timing
- Reset values: busy = 0, done = 0, F = 0, status = 4'b0000, state = IDLE.
- One-cycle ops: start accepted at edge t; done = 1 and F valid in cycle t+1. The earliest next acceptance is t+2.
- MUL: RUN occupies cycles t+1..t+N; done in cycle t+N+1. Total latency is N+1 cycles.
- `busy` is high from t+1 through the DONE cycle inclusive.
- `start` and `reset` in the same cycle: reset wins, and the request is dropped.

## Configuration
- Macro `ALU_MULTICYCLE_MUL_EN`.
- Defined: FS[4:2] = 110 is the iterative multiplier described above, and the RUN state exists.
- Undefined: the multiplier, accumulator, counter and RUN state are not compiled. FS[4:2] = 110 completes as a one-cycle op with F = 0 and status = 4'b0001 (Z set).

## Test plan
- ADD: N = 64, A = 5, B = 3, FS = 5'b01000, C0 = 0, start pulse → done one cycle later; F = 8, status = 4'b0000.
- SUB, equal operands: A = B = 5, FS = 5'b01010, C0 = 1 → F = 0, status = 4'b0101 (C = 1, Z = 1).
- MUL overflow, macro defined: A = B = 64'h1_0000_0000, FS = 5'b11000 → busy high for 65 cycles, done at t+65, F = 0, status = 4'b1001.
- Shifts: A = 64'h8000_0000_0000_0001, B = 1. ASR → F = 64'hC000_0000_0000_0000, N = 1. LSR → F = 64'h4000_0000_0000_0000.
- Start while busy: pulse `start` with an ADD in cycle t+10 of a MUL → ignored. The MUL result is unchanged, and exactly one done pulse occurs.
- Reset mid-MUL: assert reset at t+20 → next cycle busy = 0, F = 0, status = 0, and no done pulse through the following 70 cycles.
